// File: rtl/gpu_pkg.sv
// Shared GPU core definitions: controller FSM states, default core geometry and
// the block-id / thread-count field widths used by the dispatcher.
package gpu_pkg;

  localparam int THREADS_PER_BLOCK_DEF = 4;
  localparam int PC_BITS_DEF           = 8;
  localparam int INSTR_BITS_DEF        = 16;
  localparam int BLOCK_ID_BITS         = 4;
  localparam int THREAD_COUNT_BITS     = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_REQUEST = 3'd3,
    S_WAIT    = 3'd4,
    S_EXECUTE = 3'd5,
    S_UPDATE  = 3'd6,
    S_DONE    = 3'd7
  } core_state_e;

endpackage

// File: rtl/core_block_controller_if.sv
// Core controller bus: dispatcher handshake, fetch port, pipeline stage enables.
// master = the core controller, slave = dispatcher/fetcher/decoder/LSU side.
interface core_block_controller_if #(
  parameter int THREADS_PER_BLOCK = gpu_pkg::THREADS_PER_BLOCK_DEF,
  parameter int PC_BITS           = gpu_pkg::PC_BITS_DEF,
  parameter int INSTR_BITS        = gpu_pkg::INSTR_BITS_DEF
) ();

  logic                                   core_reset;
  logic                                   core_start;
  logic [gpu_pkg::BLOCK_ID_BITS-1:0]      core_block_id;
  logic [gpu_pkg::THREAD_COUNT_BITS-1:0]  core_thread_count;
  logic                                   core_done;
  logic [gpu_pkg::BLOCK_ID_BITS-1:0]      block_id;
  logic [THREADS_PER_BLOCK-1:0]           thread_enable;
  logic [PC_BITS-1:0]                     pc;
  logic                                   instr_req;
  logic [PC_BITS-1:0]                     instr_addr;
  logic                                   instr_valid;
  logic [INSTR_BITS-1:0]                  instr_data;
  logic [INSTR_BITS-1:0]                  instr;
  logic                                   decode_en;
  logic                                   mem_req;
  logic [THREADS_PER_BLOCK-1:0]           lsu_busy;
  logic                                   exec_en;
  logic                                   update_en;
  logic                                   is_ret;
  logic [THREADS_PER_BLOCK*PC_BITS-1:0]   next_pc;
  logic                                   diverge_err;

  modport master (
    input  core_reset, core_start, core_block_id, core_thread_count,
           instr_valid, instr_data, lsu_busy, is_ret, next_pc,
    output core_done, block_id, thread_enable, pc, instr_req, instr_addr,
           instr, decode_en, mem_req, exec_en, update_en, diverge_err
  );

  modport slave (
    output core_reset, core_start, core_block_id, core_thread_count,
           instr_valid, instr_data, lsu_busy, is_ret, next_pc,
    input  core_done, block_id, thread_enable, pc, instr_req, instr_addr,
           instr, decode_en, mem_req, exec_en, update_en, diverge_err
  );

endinterface

// File: rtl/pc_converge.sv
// Selects lane 0's next PC; with CORE_DIVERGE_DETECT_EN defined also flags any
// enabled lane whose next PC disagrees with lane 0.
module pc_converge #(
  parameter int THREADS_PER_BLOCK = gpu_pkg::THREADS_PER_BLOCK_DEF,
  parameter int PC_BITS           = gpu_pkg::PC_BITS_DEF
) (
  input  logic [THREADS_PER_BLOCK*PC_BITS-1:0] next_pc,
  input  logic [THREADS_PER_BLOCK-1:0]         lane_en,
  output logic [PC_BITS-1:0]                   sel_pc,
  output logic                                 mismatch
);

  assign sel_pc = next_pc[PC_BITS-1:0];

`ifdef CORE_DIVERGE_DETECT_EN
  always_comb begin
    mismatch = 1'b0;
    for (int unsigned i = 0; i < THREADS_PER_BLOCK; i++) begin
      if (lane_en[i] && (next_pc[i*PC_BITS +: PC_BITS] != sel_pc)) mismatch = 1'b1;
    end
  end
`else
  logic unused_lanes;
  assign unused_lanes = ^{next_pc[THREADS_PER_BLOCK*PC_BITS-1:PC_BITS], lane_en};
  assign mismatch     = 1'b0;
`endif

endmodule

// File: rtl/core_block_controller.sv
// Per-core block controller: launches one block and steps its lanes in lockstep
// through FETCH..UPDATE until RET. Optional feature macro: CORE_DIVERGE_DETECT_EN.
module core_block_controller
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = THREADS_PER_BLOCK_DEF,
  parameter int PC_BITS           = PC_BITS_DEF,
  parameter int INSTR_BITS        = INSTR_BITS_DEF
) (
  input logic                  clk,
  input logic                  reset,
  core_block_controller_if.master bus
);

  core_state_e                  state_q, state_d;
  logic [BLOCK_ID_BITS-1:0]     block_id_q;
  logic [THREADS_PER_BLOCK-1:0] mask_q, launch_mask;
  logic [PC_BITS-1:0]           pc_q, sel_pc;
  logic [INSTR_BITS-1:0]        instr_q;
  logic                         lane_mismatch;

  // Lane i runs when i < count; counts beyond the core width enable every lane.
  always_comb begin
    launch_mask = '0;
    for (int unsigned i = 0; i < THREADS_PER_BLOCK; i++) begin
      launch_mask[i] = (i < 32'(bus.core_thread_count));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.core_done = 1'b0;
    bus.instr_req = 1'b0;
    bus.decode_en = 1'b0;
    bus.mem_req   = 1'b0;
    bus.exec_en   = 1'b0;
    bus.update_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.core_start) state_d = (bus.core_thread_count == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        bus.instr_req = 1'b1;
        if (bus.instr_valid) state_d = S_DECODE;
      end
      S_DECODE: begin
        bus.decode_en = 1'b1;
        state_d       = S_REQUEST;
      end
      S_REQUEST: begin
        bus.mem_req = 1'b1;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if ((bus.lsu_busy & mask_q) == '0) state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        bus.exec_en = 1'b1;
        state_d     = S_UPDATE;
      end
      S_UPDATE: begin
        bus.update_en = 1'b1;
        state_d       = bus.is_ret ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        bus.core_done = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.core_reset) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      block_id_q <= '0;
      mask_q     <= '0;
      pc_q       <= '0;
      instr_q    <= '0;
    end else if (bus.core_reset) begin
      block_id_q <= '0;
      mask_q     <= '0;
      pc_q       <= '0;
      instr_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.core_start) begin
            block_id_q <= bus.core_block_id;
            mask_q     <= launch_mask;
            pc_q       <= '0;
          end
        end
        S_FETCH:  if (bus.instr_valid) instr_q <= bus.instr_data;
        S_UPDATE: if (!bus.is_ret) pc_q <= sel_pc;
        default: ;
      endcase
    end
  end

  pc_converge #(
    .THREADS_PER_BLOCK(THREADS_PER_BLOCK),
    .PC_BITS          (PC_BITS)
  ) u_pc_converge (
    .next_pc (bus.next_pc),
    .lane_en (mask_q),
    .sel_pc  (sel_pc),
    .mismatch(lane_mismatch)
  );

`ifdef CORE_DIVERGE_DETECT_EN
  logic diverge_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                                   diverge_q <= 1'b0;
    else if (bus.core_reset)                                     diverge_q <= 1'b0;
    else if (state_q == S_UPDATE && !bus.is_ret && lane_mismatch) diverge_q <= 1'b1;
  end
  assign bus.diverge_err = diverge_q;
`else
  logic unused_mismatch;
  assign unused_mismatch = lane_mismatch;
  assign bus.diverge_err = 1'b0;
`endif

  assign bus.block_id      = block_id_q;
  assign bus.thread_enable = mask_q;
  assign bus.pc            = pc_q;
  assign bus.instr_addr    = pc_q;
  assign bus.instr         = instr_q;

endmodule

// File: tb/tb_core_block_controller.sv
// Scoreboard bench for core_block_controller: a program-level reference model
// predicts fetch addresses/cycles and block completion; a monitor checks them.
module tb_core_block_controller;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  bit   abort;

  core_block_controller_if #(.THREADS_PER_BLOCK(4), .PC_BITS(8), .INSTR_BITS(16)) bus ();

  core_block_controller #(
    .THREADS_PER_BLOCK(4),
    .PC_BITS          (8),
    .INSTR_BITS       (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Program tables, indexed by pc
  bit         ret_tbl    [256];
  int         fdelay_tbl [256];
  int         blen_tbl   [256];
  logic [3:0] bpat_tbl   [256];
  logic [7:0] np_tbl     [256][4];
  logic [3:0] cur_mask;

  typedef struct {
    bit          is_done;
    logic [7:0]  addr;
    logic [15:0] data;
    int          cyc;
    logic [3:0]  mask;
    logic [3:0]  id;
    logic        div;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [15:0] mkdata(input logic [7:0] a);
    return {a ^ 8'h5A, a};
  endfunction

  assign bus.is_ret = ret_tbl[bus.pc];
  always_comb begin
    bus.next_pc = '0;
    for (int i = 0; i < 4; i++) bus.next_pc[i*8 +: 8] = np_tbl[bus.pc][i];
  end

  // Fetcher / LSU responder
  initial begin : responder
    int         vcnt;
    int         rem;
    logic [3:0] pat;
    logic [3:0] noise;
    vcnt = 0; rem = 0; pat = '0;
    bus.instr_valid = 1'b0;
    bus.instr_data  = '0;
    bus.lsu_busy    = '0;
    forever begin
      @(posedge clk); #2;
      noise = 4'($urandom) & ~cur_mask;
      if (reset || bus.core_reset) begin
        vcnt = 0; rem = 0;
        bus.instr_valid = 1'b0;
        bus.lsu_busy    = noise;
      end else begin
        if (bus.instr_req) begin
          if (vcnt >= fdelay_tbl[bus.instr_addr]) begin
            bus.instr_valid = 1'b1;
            bus.instr_data  = mkdata(bus.instr_addr);
          end else begin
            bus.instr_valid = 1'b0;
            bus.instr_data  = 16'($urandom);
          end
          vcnt++;
        end else begin
          bus.instr_valid = 1'b0;
          bus.instr_data  = 16'($urandom);
          vcnt = 0;
        end
        if (bus.mem_req) begin
          rem = blen_tbl[bus.pc];
          pat = bpat_tbl[bus.pc];
          bus.lsu_busy = noise;
        end else if (rem > 0) begin
          bus.lsu_busy = pat | noise;
          rem--;
        end else begin
          bus.lsu_busy = noise;
        end
      end
    end
  end

  // Monitor: pops expectations when the DUT presents a fetch or completes
  initial begin : monitor
    exp_t        e;
    logic        req_prev, done_prev;
    logic [15:0] last_data;
    req_prev = 1'b0; done_prev = 1'b0; last_data = '0;
    forever begin
      @(negedge clk); #1;
      if (!abort && !reset) begin
        if (bus.instr_req && !req_prev) begin
          checks++;
          if (exp_q.size() == 0 || exp_q[0].is_done) begin
            errors++;
            $display("FAIL unexpected_req cyc=%0d addr=%0d required no fetch", cyc, bus.instr_addr);
          end
        end
        if (bus.instr_req && bus.instr_valid && exp_q.size() != 0 && !exp_q[0].is_done) begin
          e = exp_q.pop_front();
          last_data = e.data;
          checks++;
          if (bus.instr_addr !== e.addr || cyc != e.cyc) begin
            errors++;
            $display("FAIL fetch got addr=%0d cyc=%0d required addr=%0d cyc=%0d",
                     bus.instr_addr, cyc, e.addr, e.cyc);
          end
        end
        if (bus.decode_en) begin
          checks++;
          if (bus.instr !== last_data) begin
            errors++;
            $display("FAIL instr got %h required %h", bus.instr, last_data);
          end
        end
        if (bus.core_done && !done_prev) begin
          checks++;
          if (exp_q.size() == 0 || !exp_q[0].is_done) begin
            errors++;
            $display("FAIL unexpected_done cyc=%0d required no completion", cyc);
          end else begin
            e = exp_q.pop_front();
            if (cyc != e.cyc || bus.thread_enable !== e.mask || bus.block_id !== e.id ||
                bus.diverge_err !== e.div) begin
              errors++;
              $display("FAIL done got cyc=%0d en=%b id=%0d div=%b required cyc=%0d en=%b id=%0d div=%b",
                       cyc, bus.thread_enable, bus.block_id, bus.diverge_err,
                       e.cyc, e.mask, e.id, e.div);
            end
          end
        end
      end
      req_prev  = bus.instr_req;
      done_prev = bus.core_done;
    end
  end

  task automatic clear_prog();
    for (int p = 0; p < 256; p++) begin
      ret_tbl[p] = 1'b0; fdelay_tbl[p] = 0; blen_tbl[p] = 0; bpat_tbl[p] = '0;
      for (int i = 0; i < 4; i++) np_tbl[p][i] = 8'(p + 1);
    end
  endtask

  task automatic gen_prog();
    bit         used[256];
    logic [7:0] p, nx;
    int         n;
    clear_prog();
    n = $urandom_range(1, 5);
    p = '0;
    for (int k = 0; k < n; k++) begin
      used[p] = 1'b1;
      fdelay_tbl[p] = $urandom_range(0, 3);
      blen_tbl[p]   = $urandom_range(0, 4);
      bpat_tbl[p]   = 4'($urandom);
      nx = 8'($urandom);
      while (used[nx]) nx = nx + 8'd1;
      for (int i = 0; i < 4; i++) np_tbl[p][i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : nx;
      np_tbl[p][0] = nx;
      if (k == n - 1) ret_tbl[p] = 1'b1;
      else            p = nx;
    end
  endtask

  // Launch a block and push the predicted fetch/completion sequence
  task automatic launch(input int cnt, input logic [3:0] id);
    exp_t       e;
    int         t, s;
    logic [7:0] p;
    logic [3:0] m;
    logic       dv;
    @(negedge clk);
    m = '0;
    for (int i = 0; i < 4; i++) m[i] = (i < cnt);
    cur_mask = m;
    bus.core_start        = 1'b1;
    bus.core_block_id     = id;
    bus.core_thread_count = 8'(cnt);
    t = cyc + 1; p = '0; dv = 1'b0;
    e.mask = m; e.id = id; e.data = '0; e.addr = '0; e.div = 1'b0;
    if (cnt == 0) begin
      e.is_done = 1'b1; e.cyc = t;
      exp_q.push_back(e);
    end else begin
      for (int k = 0; k < 64; k++) begin
        t += fdelay_tbl[p];
        e.is_done = 1'b0; e.addr = p; e.data = mkdata(p); e.cyc = t;
        exp_q.push_back(e);
        s = ((bpat_tbl[p] & m) != '0) ? blen_tbl[p] : 0;
        t += 6 + s;
        if (ret_tbl[p]) begin
          e.is_done = 1'b1; e.cyc = t; e.div = dv; e.addr = '0; e.data = '0;
          exp_q.push_back(e);
          break;
        end
`ifdef CORE_DIVERGE_DETECT_EN
        for (int i = 0; i < 4; i++) if (m[i] && np_tbl[p][i] != np_tbl[p][0]) dv = 1'b1;
`endif
        p = np_tbl[p][0];
      end
    end
    @(negedge clk);
    bus.core_start        = 1'b0;
    bus.core_block_id     = 4'($urandom);
    bus.core_thread_count = 8'($urandom);
  endtask

  task automatic check_idle(input string name);
    logic [46:0] v;
    v = {bus.core_done, bus.block_id, bus.thread_enable, bus.pc, bus.instr_req, bus.instr_addr,
         bus.instr, bus.decode_en, bus.mem_req, bus.exec_en, bus.update_en, bus.diverge_err};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL idle_%s outputs=%h required 0", name, v);
    end
  endtask

  // Soft reset with core_start held high: reset must win
  task automatic soft_reset(input string name);
    @(negedge clk);
    abort = 1'b1;
    bus.core_reset = 1'b1;
    bus.core_start = 1'b1;
    exp_q.delete();
    @(negedge clk);
    bus.core_reset = 1'b0;
    bus.core_start = 1'b0;
    #1;
    check_idle(name);
    abort = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 3000 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL timeout_%s pending=%0d required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_block(input int cnt, input logic [3:0] id, input string name);
    launch(cnt, id);
    drain(name);
    bus.core_start        = 1'b1;
    bus.core_thread_count = 8'd2;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (bus.core_done !== 1'b1 || bus.instr_req !== 1'b0 || bus.block_id !== id) begin
      errors++;
      $display("FAIL done_hold_%s got done=%b req=%b id=%0d required done=1 req=0 id=%0d",
               name, bus.core_done, bus.instr_req, bus.block_id, id);
    end
    soft_reset(name);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog cyc=%0d required completion", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    checks = 0; errors = 0; abort = 1'b0; cur_mask = '0;
    reset = 1'b1;
    bus.core_reset = 1'b0; bus.core_start = 1'b0;
    bus.core_block_id = '0; bus.core_thread_count = '0;
    clear_prog();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle("reset");

    clear_prog(); ret_tbl[0] = 1'b1;
    run_block(3, 4'h3, "ret_at_0");

    clear_prog();
    run_block(0, 4'h9, "count_zero");

    clear_prog(); ret_tbl[0] = 1'b1; blen_tbl[0] = 5; bpat_tbl[0] = 4'b0001;
    run_block(4, 4'h1, "stall_lane0");
    bpat_tbl[0] = 4'b1000;
    run_block(2, 4'h2, "busy_disabled");

    clear_prog(); ret_tbl[2] = 1'b1;
    run_block(4, 4'h7, "three_instr");

    clear_prog(); ret_tbl[3] = 1'b1;
    np_tbl[0][0] = 8'd3; np_tbl[0][1] = 8'd3; np_tbl[0][2] = 8'd7; np_tbl[0][3] = 8'd3;
    run_block(4, 4'h6, "diverge_4");
    run_block(2, 4'h6, "diverge_2");

    clear_prog(); ret_tbl[0] = 1'b1; blen_tbl[0] = 40; bpat_tbl[0] = 4'hF;
    launch(4, 4'hA);
    for (int k = 0; k < 50 && !bus.mem_req; k++) @(negedge clk);
    if (!bus.mem_req) begin
      checks++; errors++;
      $display("FAIL timeout_mem_req got 0 required 1");
    end
    @(negedge clk);
    soft_reset("abort_wait");

    clear_prog(); fdelay_tbl[0] = 30; ret_tbl[0] = 1'b1;
    launch(4, 4'h3);
    @(negedge clk);
    soft_reset("abort_fetch");

    clear_prog(); ret_tbl[1] = 1'b1;
    run_block(3, 4'h5, "relaunch");

    clear_prog(); ret_tbl[0] = 1'b1;
    run_block(200, 4'hC, "count_clamp");

    for (int r = 0; r < 30; r++) begin
      gen_prog();
      run_block($urandom_range(0, 9), 4'($urandom), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
